// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants used by the counter and the existing decoder.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 16;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Index width for a WIDTH-bit vector; never less than 1 so ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Combinational binary-to-Gray encoder for a WIDTH-bit value.
module gray_bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [GRAY_MAX_WIDTH-1:0] bin_ext;
  logic [GRAY_MAX_WIDTH-1:0] gray_ext;

  always_comb begin
    bin_ext            = '0;
    bin_ext[WIDTH-1:0] = bin;
    gray_ext           = bin2gray(bin_ext);
  end

  assign gray = gray_ext[WIDTH-1:0];

endmodule

// File: rtl/gray_encoder_counter.sv
// Up/down binary counter with registered Gray output, wrap pulse and toggled-bit index.
module gray_encoder_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_bin,
  output logic [WIDTH-1:0]          bin_out,
  output logic [WIDTH-1:0]          gray_out,
  output logic                      wrap,
  output logic                      chg_vld,
  output logic [clog2(WIDTH)-1:0]   chg_idx
);

  localparam int IDX_W = clog2(WIDTH);

  logic             step;
  logic             wrap_next;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] gray_diff;
  logic [IDX_W-1:0] idx_next;

  always_comb begin
    step      = en && !load;
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        bin_next  = bin_out + 1'b1;
        wrap_next = (bin_out == '1);
      end else begin
        bin_next  = bin_out - 1'b1;
        wrap_next = (bin_out == '0);
      end
    end
  end

  gray_bin2gray #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // A single count step flips exactly one Gray bit; locate it from the old/new XOR.
  always_comb begin
    gray_diff = gray_out ^ gray_next;
    idx_next  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (gray_diff[i]) idx_next = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
      chg_vld  <= 1'b0;
      chg_idx  <= '0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= step && wrap_next;
      chg_vld  <= step;
      if (load)      chg_idx <= '0;
      else if (step) chg_idx <= idx_next;
    end
  end

endmodule

// File: tb/tb_gray_encoder_counter.sv
// Directed bench for gray_encoder_counter at WIDTH=4 with hand-computed expectations.
module tb_gray_encoder_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] bin_out;
  logic [3:0] gray_out;
  logic       wrap;
  logic       chg_vld;
  logic [1:0] chg_idx;

  int n_cmp;
  int n_bad;

  gray_encoder_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .wrap     (wrap),
    .chg_vld  (chg_vld),
    .chg_idx  (chg_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                         input logic ew, input logic ev, input logic [1:0] ei);
    chk({tag, ".bin"},  16'(bin_out),  16'(eb));
    chk({tag, ".gray"}, 16'(gray_out), 16'(eg));
    chk({tag, ".wrap"}, 16'(wrap),     16'(ew));
    chk({tag, ".vld"},  16'(chg_vld),  16'(ev));
    chk({tag, ".idx"},  16'(chg_idx),  16'(ei));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] up_gray [16];
  logic [1:0] up_idx  [16];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    up_idx  = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};

    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'h0;
    #1;
    chk_all("reset_async", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    tick();
    tick();
    chk_all("reset_held", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // Reset ignores load/en.
    load = 1'b1; load_bin = 4'hA; en = 1'b1;
    tick();
    chk_all("reset_ignores_load", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    load = 1'b0; en = 1'b0;
    rst = 1'b0;
    tick();
    chk_all("post_reset_idle", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // Full up count.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_all($sformatf("up%0d", i), 4'((i + 1) % 16), up_gray[i], (i == 15), 1'b1, up_idx[i]);
    end

    // Down wrap from 0.
    up_dn = 1'b0;
    tick();
    chk_all("down_wrap", 4'hF, 4'b1000, 1'b1, 1'b1, 2'd3);
    en = 1'b0;
    tick();
    chk_all("down_wrap_after", 4'hF, 4'b1000, 1'b0, 1'b0, 2'd3);

    // Load beats enable.
    load = 1'b1; en = 1'b1; up_dn = 1'b1; load_bin = 4'b1011;
    tick();
    chk_all("load_vs_en", 4'b1011, 4'b1110, 1'b0, 1'b0, 2'd0);

    // chg_idx from bin 0011.
    load_bin = 4'b0011; en = 1'b0;
    tick();
    chk_all("load_0011", 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk_all("idx_step", 4'b0100, 4'b0110, 1'b0, 1'b1, 2'd2);
    en = 1'b0;
    tick();
    chk_all("idx_pulse_end", 4'b0100, 4'b0110, 1'b0, 1'b0, 2'd2);

    // Hold for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 4'b0100, 4'b0110, 1'b0, 1'b0, 2'd2);
    end

    // Direction change on consecutive cycles.
    en = 1'b1; up_dn = 1'b0;
    tick();
    chk_all("dir_down", 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd2);
    up_dn = 1'b0;
    tick();
    chk_all("dir_down2", 4'b0010, 4'b0011, 1'b0, 1'b1, 2'd0);
    up_dn = 1'b1;
    tick();
    chk_all("dir_up", 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd0);

    // Mid-cycle asynchronous reset while counting.
    #2;
    rst = 1'b1;
    #1;
    chk_all("reset_mid", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    #2;
    rst = 1'b0;
    tick();
    chk_all("first_after_reset", 4'h1, 4'b0001, 1'b0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
